// File: rtl/pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg
//   Elastic pipeline register: DEPTH stages of WIDTH-bit data with a
//   valid/ready handshake on both sides. Empty stages always accept from
//   upstream, so bubbles collapse while the output is stalled. A synchronous
//   flush discards every held entry but leaves the data flops untouched.
//
//   Build option:
//     PIPE_REG_SKID_EN  adds a one-entry skid buffer in front of stage 0.
//                       in_ready then comes from a flop and has no
//                       combinational path from out_ready. Capacity is
//                       DEPTH+1. Without the macro in_ready is combinational
//                       from out_ready and capacity is DEPTH.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     flush      in   synchronous flush of all held entries
//     in_valid   in   upstream data valid
//     in_ready   out  block accepts in_data this cycle
//     in_data    in   upstream data [WIDTH]
//     out_valid  out  out_data valid
//     out_ready  in   downstream accepts out_data this cycle
//     out_data   out  data of the last stage [WIDTH]
//     count      out  number of valid entries held, skid included [CW]
// -----------------------------------------------------------------------------
module pipe_reg #(
    parameter int               WIDTH      = 16,
    parameter int               DEPTH      = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    parameter int               CW         = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_adv;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_s0_valid;
    logic [WIDTH-1:0] w_s0_data;

    // A stage may advance when it, or any stage downstream of it, is empty,
    // or when the output is being drained. Written as a reduction over the
    // downstream valids so the chain has no self-referencing bits.
    for (genvar g = 0; g < DEPTH; g++) begin : g_adv
        assign w_adv[g] = out_ready || !(&r_valid[DEPTH-1:g]);
    end

    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;

`ifdef PIPE_REG_SKID_EN
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_in_rdy;
    logic             w_skid_valid_nxt;

    assign in_ready   = r_in_rdy && !flush;
    // Skid content is older than anything arriving now, so it goes first.
    assign w_s0_valid = r_skid_valid || w_in_hs;
    assign w_s0_data  = r_skid_valid ? r_skid_data : in_data;

    always_comb begin
        w_skid_valid_nxt = r_skid_valid;
        if (flush) begin
            w_skid_valid_nxt = 1'b0;
        end else if (w_adv[0]) begin
            w_skid_valid_nxt = r_skid_valid && w_in_hs;
        end else begin
            w_skid_valid_nxt = r_skid_valid || w_in_hs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= INIT_VALUE;
            r_in_rdy     <= 1'b0;
        end else begin
            r_skid_valid <= w_skid_valid_nxt;
            r_in_rdy     <= !w_skid_valid_nxt;
            if (w_in_hs && (r_skid_valid || !w_adv[0])) begin
                r_skid_data <= in_data;
            end
        end
    end
`else
    // Holds in_ready low for the first cycle out of reset.
    logic r_rdy;

    assign in_ready   = r_rdy && w_adv[0] && !flush;
    assign w_s0_valid = w_in_hs;
    assign w_s0_data  = in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= INIT_VALUE;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= w_s0_valid;
                if (w_s0_valid) begin
                    r_data[0] <= w_s0_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_adv[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_in_hs, w_out_hs})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
    assign count     = r_count;

endmodule

// File: tb/tb_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg
//   Self-checking bench for pipe_reg (WIDTH=16, DEPTH=3, INIT_VALUE=16'hA5A5).
//   Accepted words are pushed to a scoreboard queue; delivered words are
//   popped and compared. count is compared each cycle to the queue size.
//   Capacity follows PIPE_REG_SKID_EN.
// -----------------------------------------------------------------------------
module tb_pipe_reg;

    localparam int          WIDTH = 16;
    localparam int          DEPTH = 3;
    localparam int          CW    = $clog2(DEPTH + 2);
    localparam logic [15:0] INIT  = 16'hA5A5;
`ifdef PIPE_REG_SKID_EN
    localparam int          CAP   = DEPTH + 1;
`else
    localparam int          CAP   = DEPTH;
`endif

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    pipe_reg #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .INIT_VALUE (INIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // scoreboard and handshake statistics
    logic [15:0] sb_q[$];
    logic [15:0] sb_exp;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data;
    int hs_in_cnt, hs_out_cnt, first_in_cyc, first_ov_cyc, first_out_cyc, last_out_cyc;

    task automatic clr_stats();
        hs_in_cnt     = 0;
        hs_out_cnt    = 0;
        first_in_cyc  = -1;
        first_ov_cyc  = -1;
        first_out_cyc = -1;
        last_out_cyc  = -1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("count", 32'(count), sb_q.size());
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_data  = out_data;
            if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
                hs_in_cnt++;
                if (first_in_cyc < 0) first_in_cyc = cyc;
            end
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    sb_exp = sb_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(sb_exp));
                end
                hs_out_cnt++;
                last_out_cyc = cyc;
                if (first_out_cyc < 0) first_out_cyc = cyc;
            end
            if (flush) sb_q.delete();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded).
    task automatic send(input logic [15:0] d);
        int   t;
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        t        = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) chk("send_accept", 32'(acc), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int nxt;
        logic acc;

        // reset with in_valid high
        clr_stats();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b0;
        #23;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 32'(INIT));
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        #9;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rel_in_ready_pre", 32'(in_ready), 0);
        tick(1);
        chk("rel_in_ready", 32'(in_ready), 1);

        // back-to-back stream
        out_ready = 1'b1;
        clr_stats();
        for (int k = 1; k <= 8; k++) send(16'(k));
        in_valid = 1'b0;
        tick(8);
        chk("stream_latency", first_ov_cyc - first_in_cyc, DEPTH);
        chk("stream_count", hs_out_cnt, 8);
        chk("stream_rate", last_out_cyc - first_out_cyc, 7);

        // back-pressure: offer 5 words into a stalled pipe
        out_ready = 1'b0;
        clr_stats();
        nxt      = 1;
        in_valid = 1'b1;
        in_data  = 16'(nxt);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = in_ready && in_valid;
            @(posedge clk);
            #1;
            if (acc && nxt < 5) begin
                nxt++;
                in_data = 16'(nxt);
            end else if (acc) begin
                in_valid = 1'b0;
            end
        end
        chk("bp_accepted", hs_in_cnt, CAP);
        chk("bp_count", 32'(count), CAP);
        chk("bp_out_data", 32'(out_data), 32'h1);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        for (int k = nxt; k <= 5; k++) send(16'(k));
        in_valid = 1'b0;
        tick(8);
        chk("bp_drained", hs_out_cnt, 5);

        // bubble collapse
        out_ready = 1'b0;
        clr_stats();
        send(16'h0011);
        in_valid = 1'b0;
        tick(1);
        send(16'h0022);
        in_valid = 1'b0;
        tick(3);
        chk("bub_count", 32'(count), 2);
        chk("bub_out_valid", 32'(out_valid), 1);
        chk("bub_out_data", 32'(out_data), 32'h11);
        clr_stats();
        out_ready = 1'b1;
        tick(4);
        chk("bub_delivered", hs_out_cnt, 2);
        chk("bub_consecutive", last_out_cyc - first_out_cyc, 1);

        // flush with two entries held and input offered
        out_ready = 1'b0;
        send(16'h0031);
        send(16'h0032);
        chk("fl_count_pre", 32'(count), 2);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        flush    = 1'b1;
        @(negedge clk);
        chk("fl_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 0);
        chk("fl_count", 32'(count), 0);
        chk("fl_data_hold", 32'(out_data), 32'h22);
        out_ready = 1'b1;
        clr_stats();
        send(16'h0033);
        in_valid = 1'b0;
        tick(6);
        chk("fl_after", hs_out_cnt, 1);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send(16'h0041);
        send(16'h0042);
        send(16'h0043);
        in_valid = 1'b0;
        tick(2);
        chk("ar_count_pre", 32'(count), 3);
        chk("ar_data_pre", 32'(out_data), 32'h41);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 0);
        chk("ar_out_data", 32'(out_data), 32'(INIT));
        chk("ar_count", 32'(count), 0);
        chk("ar_in_ready", 32'(in_ready), 0);
        tick(1);
        #2;
        rst_n = 1'b1;
        tick(1);
        chk("ar_rel_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        clr_stats();
        for (int k = 0; k < 4; k++) send(16'h0051 + 16'(k));
        in_valid = 1'b0;
        tick(8);
        chk("ar_in_cnt", hs_in_cnt, 4);
        chk("ar_out_cnt", hs_out_cnt, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
